// File: rtl/fetch_queue.sv
// fetch_queue: FIFO of fetched {Instr, PC, PC+4} between fetch and decode.
// The head entry falls through to decode. FullF stalls the PC. FlushQ empties
// the queue on a redirect.
module fetch_queue #(
    parameter int          XLEN  = 32,
    parameter int          DEPTH = 4,
    parameter logic [31:0] NOP   = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ValidF,
    input  logic [31:0]              InstrF,
    input  logic [XLEN-1:0]          PCF,
    input  logic [XLEN-1:0]          PCPlus4F,
    input  logic                     FlushQ,
    input  logic                     StallD,
    output logic                     FullF,
    output logic                     ValidD,
    output logic [31:0]              InstrD,
    output logic [XLEN-1:0]          PCD,
    output logic [XLEN-1:0]          PCPlus4D,
    output logic [$clog2(DEPTH):0]   CountQ
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Entry storage. It is never reset, because the pointers alone define
    // which entries are live.
    logic [31:0]      r_instr [DEPTH];
    logic [XLEN-1:0]  r_pc    [DEPTH];
    logic [XLEN-1:0]  r_pc4   [DEPTH];

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic             w_full;
    logic             w_valid;
    logic             w_enq;
    logic             w_deq;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_valid = (r_count != '0);

    // A full queue refuses the enqueue even when a dequeue frees a slot in
    // the same cycle. This keeps FullF purely registered.
    assign w_enq = ValidF & ~w_full & ~FlushQ;
    assign w_deq = w_valid & ~StallD & ~FlushQ;

    // Write the incoming fetch bundle at the write pointer.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_instr[r_wptr] <= InstrF;
            r_pc[r_wptr]    <= PCF;
            r_pc4[r_wptr]   <= PCPlus4F;
        end
    end

    // Update the pointers and occupancy. Reset has priority over flush,
    // and flush has priority over normal traffic.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (FlushQ) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_deq) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign FullF    = w_full;
    assign ValidD   = w_valid;
    assign CountQ   = r_count;
    assign InstrD   = w_valid ? r_instr[r_rptr] : NOP;
    assign PCD      = w_valid ? r_pc[r_rptr]    : '0;
    assign PCPlus4D = w_valid ? r_pc4[r_rptr]   : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue.
module tb_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        ValidF;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        FlushQ;
    logic        StallD;
    logic        FullF;
    logic        ValidD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic [2:0]  CountQ;

    int n_cmp;
    int n_err;

    fetch_queue #(.XLEN(32), .DEPTH(4), .NOP(32'h0000_0013)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ValidF   (ValidF),
        .InstrF   (InstrF),
        .PCF      (PCF),
        .PCPlus4F (PCPlus4F),
        .FlushQ   (FlushQ),
        .StallD   (StallD),
        .FullF    (FullF),
        .ValidD   (ValidD),
        .InstrD   (InstrD),
        .PCD      (PCD),
        .PCPlus4D (PCPlus4D),
        .CountQ   (CountQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word tagged with its PC, so a wrong entry is visible.
    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        ValidF   = v;
        PCF      = pc;
        PCPlus4F = pc + 32'd4;
        InstrF   = instr_of(pc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".FullF"},    {63'd0, FullF},  64'd0);
        check({tag, ".ValidD"},   {63'd0, ValidD}, 64'd0);
        check({tag, ".InstrD"},   {32'd0, InstrD}, 64'h13);
        check({tag, ".PCD"},      {32'd0, PCD},    64'd0);
        check({tag, ".PCPlus4D"}, {32'd0, PCPlus4D}, 64'd0);
        check({tag, ".CountQ"},   {61'd0, CountQ}, 64'd0);
    endtask

    initial begin
        logic [31:0] exp_pc;
        int          sent;
        int          rcvd;
        n_cmp  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        FlushQ = 1'b0;
        StallD = 1'b0;
        drive(1'b0, 32'h0);
        step();
        step();
        rst_n = 1'b1;

        // Reset values
        check_reset_outputs("reset");

        // Empty: idle cycle keeps the NOP output
        step();
        check("empty.ValidD", {63'd0, ValidD}, 64'd0);
        check("empty.InstrD", {32'd0, InstrD}, 64'h13);
        check("empty.PCD",    {32'd0, PCD},    64'd0);

        // Single enqueue into empty queue: visible one cycle later, no bypass
        StallD = 1'b1;
        drive(1'b1, 32'h100);
        check("single.nobypass", {63'd0, ValidD}, 64'd0);
        step();
        drive(1'b0, 32'h0);
        check("single.ValidD",   {63'd0, ValidD}, 64'd1);
        check("single.PCD",      {32'd0, PCD},      64'h100);
        check("single.PCPlus4D", {32'd0, PCPlus4D}, 64'h104);
        check("single.InstrD",   {32'd0, InstrD},   {32'd0, 32'hC0DE_0100});
        StallD = 1'b0;
        step();
        check("single.drained", {63'd0, ValidD}, 64'd0);

        // Reset and fill with decode stalled
        rst_n = 1'b0;
        step();
        rst_n  = 1'b1;
        StallD = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i * 4));
            step();
        end
        drive(1'b0, 32'h0);
        check("fill.FullF",  {63'd0, FullF},  64'd1);
        check("fill.CountQ", {61'd0, CountQ}, 64'd4);
        StallD = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("drain.PCD",    {32'd0, PCD},    64'(i * 4));
            check("drain.InstrD", {32'd0, InstrD}, {32'd0, instr_of(32'(i * 4))});
            step();
        end
        check("drain.empty", {63'd0, ValidD}, 64'd0);

        // Full with simultaneous dequeue: enqueue is refused
        StallD = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i * 4));
            step();
        end
        check("full2.FullF", {63'd0, FullF}, 64'd1);
        StallD = 1'b0;
        drive(1'b1, 32'h40);
        step();
        check("fulldeq.CountQ", {61'd0, CountQ}, 64'd3);
        check("fulldeq.FullF",  {63'd0, FullF},  64'd0);
        check("fulldeq.PCD",    {32'd0, PCD},    64'h4);
        step();
        drive(1'b0, 32'h0);
        check("fulldeq.accept.CountQ", {61'd0, CountQ}, 64'd3);
        check("fulldeq.PCD8", {32'd0, PCD}, 64'h8);
        step();
        check("fulldeq.PCDC", {32'd0, PCD}, 64'hC);
        step();
        check("fulldeq.PCD40", {32'd0, PCD}, 64'h40);
        step();
        check("fulldeq.empty", {63'd0, ValidD}, 64'd0);

        // Wrap-around: 10 instructions, decode stalls every other cycle
        exp_pc = 32'h0;
        sent   = 0;
        rcvd   = 0;
        for (int cyc = 0; cyc < 100 && rcvd < 10; cyc++) begin
            StallD = cyc[0];
            drive(sent < 10, 32'(sent * 4));
            if (ValidD && !StallD) begin
                check("wrap.PCD", {32'd0, PCD}, {32'd0, exp_pc});
                exp_pc = exp_pc + 32'd4;
                rcvd++;
            end
            if (ValidF && !FullF) sent++;
            step();
        end
        drive(1'b0, 32'h0);
        StallD = 1'b0;
        check("wrap.count_received", 64'(rcvd), 64'd10);
        check("wrap.empty", {61'd0, CountQ}, 64'd0);

        // Flush with a same-cycle enqueue while decode is stalled
        StallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h300 + 32'(i * 4));
            step();
        end
        check("flush.pre.CountQ", {61'd0, CountQ}, 64'd3);
        FlushQ = 1'b1;
        drive(1'b1, 32'h200);
        step();
        FlushQ = 1'b0;
        drive(1'b0, 32'h0);
        check("flush.ValidD", {63'd0, ValidD}, 64'd0);
        check("flush.CountQ", {61'd0, CountQ}, 64'd0);
        check("flush.FullF",  {63'd0, FullF},  64'd0);
        drive(1'b1, 32'h80);
        step();
        drive(1'b0, 32'h0);
        check("flush.PCD80",  {32'd0, PCD},    64'h80);
        check("flush.CountQ1", {61'd0, CountQ}, 64'd1);
        StallD = 1'b0;
        step();
        check("flush.no200", {63'd0, ValidD}, 64'd0);

        // Reset mid-stream overrides flush
        StallD = 1'b1;
        drive(1'b1, 32'h500);
        step();
        drive(1'b1, 32'h504);
        step();
        drive(1'b0, 32'h0);
        check("midrst.pre.CountQ", {61'd0, CountQ}, 64'd2);
        rst_n  = 1'b0;
        FlushQ = 1'b1;
        step();
        rst_n  = 1'b0;
        FlushQ = 1'b0;
        rst_n  = 1'b1;
        check_reset_outputs("midrst");
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h600 + 32'(i * 4));
            step();
        end
        drive(1'b0, 32'h0);
        check("midrst.full", {63'd0, FullF}, 64'd1);
        StallD = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("midrst.PCD", {32'd0, PCD}, 64'(32'h600 + 32'(i * 4)));
            step();
        end
        check("midrst.empty", {63'd0, ValidD}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
